// File: rtl/fifo_buf.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_buf
//  Purpose  : Synchronous first-word-fall-through FIFO with valid/ready
//             handshakes on both sides, an occupancy count and a flush.
//             All status outputs derive from registered state only.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1          clock, all state updates on the rising edge
//    rst      in   1          synchronous active-high reset
//    data_i   in   DATA_SIZE  write payload
//    valid_i  in   1          write request
//    ready_o  out  1          FIFO can accept a write (not full)
//    flush    in   1          discard all stored entries
//    data_o   out  DATA_SIZE  head-of-queue payload (valid when valid_o)
//    valid_o  out  1          head entry present (not empty)
//    ready_i  in   1          consumer takes the head entry
//    count_o  out  CNT_W      occupancy, 0..DEPTH
//    full_o   out  1          count_o == DEPTH
//    empty_o  out  1          count_o == 0
// ============================================================================
module fifo_buf #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 flush,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;

  // Status flags come from the count register alone, so there is no
  // combinational path from valid_i/ready_i to ready_o/valid_o. When full,
  // ready_o stays low even if a pop happens in the same cycle.
  assign full_o  = (count == FULL_COUNT);
  assign empty_o = (count == '0);
  assign ready_o = !full_o;
  assign valid_o = !empty_o;
  assign count_o = count;

  // First-word fall-through: the head entry is always on the output.
  // A freshly written entry shows up one cycle after the push (no bypass).
  assign data_o = mem[rd_ptr];

  // Flush takes priority over both handshakes.
  always_comb begin
    push = valid_i && ready_o && !flush;
    pop  = valid_o && ready_i && !flush;
  end

  // Storage is not reset; only the pointers and the count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_buf
//  Purpose  : Self-checking bench for fifo_buf (DEPTH=4, 8-bit payload).
//             Directed stimulus pushes expected entries into a queue; a
//             monitor on the falling edge compares status and popped data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          flush;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state, updated at the falling edge ahead of each
  // rising edge so it always describes the post-edge DUT state.
  logic [DW-1:0] q [$];
  int            m_count  = 0;
  bit            mon_en   = 1'b0;
  bit            m_pushed = 1'b0;

  fifo_buf #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .flush   (flush),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int pre;
    if (mon_en) begin
      chk("count_o", 32'(count_o), 32'(m_count));
      chk("valid_o", 32'(valid_o), 32'(m_count != 0));
      chk("ready_o", 32'(ready_o), 32'(m_count != DEPTH));
      chk("full_o",  32'(full_o),  32'(m_count == DEPTH));
      chk("empty_o", 32'(empty_o), 32'(m_count == 0));
    end
    m_pushed = 1'b0;
    pre      = m_count;
    if (rst) begin
      q.delete();
      mon_en = 1'b1;
    end else if (mon_en) begin
      if (flush) begin
        q.delete();
      end else begin
        if (pre != 0 && ready_i) begin
          chk("data_o", 32'(data_o), 32'(q[0]));
          void'(q.pop_front());
        end
        if (valid_i && pre < DEPTH) begin
          q.push_back(data_i);
          m_pushed = 1'b1;
        end
      end
    end
    m_count = q.size();
  end

  // Apply inputs, then let one rising edge pass; returns 1 time unit later.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush   = f;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush = 1'b0; data_i = '0;

    // Reset, then hold reset with every other input active.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_full",  32'(full_o),  32'd0);

    // Fill to full, fifth push refused, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full",  32'(full_o),  32'd1);
    chk("fill_ready", 32'(ready_o), 32'd0);
    chk("fill_count", 32'(count_o), 32'd4);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    chk("refuse_count", 32'(count_o), 32'd4);
    idle_drain(4);
    chk("drain_empty", 32'(empty_o), 32'd1);
    // ready_i while empty does nothing.
    idle_drain(2);
    chk("empty_pop_count", 32'(count_o), 32'd0);

    // Streaming at count 2.
    step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", 32'(count_o), 32'd2);
    idle_drain(2);
    chk("stream_drained", 32'(count_o), 32'd0);

    // Full with simultaneous push+pop: pop happens, push refused.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD4, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(count_o), 32'd3);
    chk("fullpp_ready", 32'(ready_o), 32'd1);
    idle_drain(3);

    // Flush at count 3 with a concurrent push of 0x55.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    step(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0);
    chk("post_flush_count", 32'(count_o), 32'd1);
    chk("post_flush_data",  32'(data_o),  32'hE3);
    idle_drain(1);

    // Wrap-around: 3*DEPTH+1 entries with random ready_i.
    idx = 0;
    cyc = 0;
    while (idx < 3 * DEPTH + 1 && cyc < 300) begin
      step(1'b1, 8'hF0 - 8'(idx), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      if (m_pushed) idx++;
      cyc++;
    end
    chk("wrap_all_pushed", 32'(idx), 32'(3 * DEPTH + 1));
    cyc = 0;
    while (m_count != 0 && cyc < 50) begin
      idle_drain(1);
      cyc++;
    end
    chk("wrap_drained", 32'(count_o), 32'd0);

    // Reset mid-operation at count 2 with a push pending.
    step(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h72, 1'b0, 1'b0, 1'b1);
    chk("midrst_count", 32'(count_o), 32'd0);
    chk("midrst_empty", 32'(empty_o), 32'd1);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    idle_drain(2);
    chk("midrst_novalid", 32'(valid_o), 32'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
